// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive frame controller.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_e;

   localparam int DATA_BITS        = 8;
   localparam int DEFAULT_PRESCALE = 16;

   function automatic logic prescale_legal(input int unsigned p);
      return (p == 32'd8) || (p == 32'd16) || (p == 32'd32);
   endfunction

endpackage

// File: rtl/uart_rx_edge_bit_counter.sv
// Per-bit edge counter and frame bit counter; wraps edge at presc-1 and bumps bit.
// Single-cycle update, no backpressure; clear has priority over counting.
module uart_rx_edge_bit_counter #(
   parameter int PRESC_W = 6,
   parameter int BIT_W   = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en_i,
   input  logic               clr_i,
   input  logic [PRESC_W-1:0] presc_i,
   output logic [PRESC_W-1:0] edge_count_o,
   output logic [BIT_W-1:0]   bit_count_o,
   output logic               bit_end_o
);

   logic [PRESC_W-1:0] edge_q, edge_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic               wrap;

   assign wrap = (edge_q == presc_i - PRESC_W'(1));

   always_comb begin
      edge_d = edge_q;
      bit_d  = bit_q;
      if (clr_i) begin
         edge_d = '0;
         bit_d  = '0;
      end else if (en_i) begin
         if (wrap) begin
            edge_d = '0;
            bit_d  = bit_q + BIT_W'(1);
         end else begin
            edge_d = edge_q + PRESC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         edge_q <= '0;
         bit_q  <= '0;
      end else begin
         edge_q <= edge_d;
         bit_q  <= bit_d;
      end
   end

   assign edge_count_o = edge_q;
   assign bit_count_o  = bit_q;
   assign bit_end_o    = en_i && wrap;

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// UART RX frame FSM: start detect, LSB-first deserialize, parity/stop check, result pulses.
// Result pulses appear one cycle after the stop-bit end; no backpressure (pulses are not held).
module uart_rx_frame_ctrl
   import uart_rx_pkg::*;
#(
   parameter int DATA_W  = DATA_BITS,
   parameter int PRESC_W = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               rx_in,
   input  logic [PRESC_W-1:0] prescale,
   input  logic               par_en,
   input  logic               par_typ,
   input  logic               sampled_bit,
   output logic [PRESC_W-1:0] edge_count,
   output logic [3:0]         bit_count,
   output logic               dat_samp_en,
   output logic [DATA_W-1:0]  p_data,
   output logic               data_valid,
   output logic               par_err,
   output logic               stp_err
);

   rx_state_e          state_q, state_d;
   logic [PRESC_W-1:0] presc_q;
   logic               par_en_q, par_typ_q, par_fail_q;
   logic [DATA_W-1:0]  shift_q, p_data_q;
   logic               data_valid_q, par_err_q, stp_err_q;
   logic               bit_end, cnt_clr, start_det;

   uart_rx_edge_bit_counter #(.PRESC_W(PRESC_W), .BIT_W(4)) u_cnt (
      .clk          (clk),
      .rst          (rst),
      .en_i         (dat_samp_en),
      .clr_i        (cnt_clr),
      .presc_i      (presc_q),
      .edge_count_o (edge_count),
      .bit_count_o  (bit_count),
      .bit_end_o    (bit_end)
   );

   always_comb begin
      state_d     = state_q;
      dat_samp_en = (state_q != IDLE);
      start_det   = (state_q == IDLE) && !rx_in;
      case (state_q)
         IDLE:    if (!rx_in) state_d = START;
         START:   if (bit_end) state_d = sampled_bit ? IDLE : DATA;
         DATA:    if (bit_end && bit_count == 4'(DATA_W)) state_d = par_en_q ? PARITY : STOP;
         PARITY:  if (bit_end) state_d = STOP;
         STOP:    if (bit_end) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Counters sit at zero whenever the next state is IDLE, so START always begins at edge 0.
      cnt_clr = (state_d == IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc_q      <= PRESC_W'(DEFAULT_PRESCALE);
         par_en_q     <= 1'b0;
         par_typ_q    <= 1'b0;
         par_fail_q   <= 1'b0;
         shift_q      <= '0;
         p_data_q     <= '0;
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
      end else begin
         data_valid_q <= 1'b0;
         par_err_q    <= 1'b0;
         stp_err_q    <= 1'b0;
         if (start_det) begin
            presc_q    <= prescale_legal(32'(prescale)) ? prescale : PRESC_W'(DEFAULT_PRESCALE);
            par_en_q   <= par_en;
            par_typ_q  <= par_typ;
            par_fail_q <= 1'b0;
         end
         if (bit_end) begin
            case (state_q)
               DATA:   shift_q <= {sampled_bit, shift_q[DATA_W-1:1]};
               PARITY: par_fail_q <= (sampled_bit != ((^shift_q) ^ par_typ_q));
               STOP: begin
                  stp_err_q  <= ~sampled_bit;
                  par_err_q  <= par_fail_q;
                  par_fail_q <= 1'b0;
                  if (sampled_bit && !par_fail_q) begin
                     p_data_q     <= shift_q;
                     data_valid_q <= 1'b1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

   assign p_data     = p_data_q;
   assign data_valid = data_valid_q;
   assign par_err    = par_err_q;
   assign stp_err    = stp_err_q;

endmodule

// File: doc/uart_rx_frame_ctrl.md
Name: uart_rx_frame_ctrl

Overview:
Receive-side frame controller for the UART RX path. It detects the start bit and runs the per-bit edge counter and bit counter, which drive the data-sampling stage through edge_count and dat_samp_en. It consumes the majority-voted sampled_bit at the end of each bit period and deserializes 8 data bits, LSB first. It checks optional parity and the stop bit, then emits a one-cycle data_valid pulse with the byte to the RX synchronizer / register-file side.

Parameters:
DATA_W, 8, data bits per frame
PRESC_W, 6, width of prescale and edge_count

Ports:
clk  in  1  oversampling clock (prescale x baud)
rst  in  1  asynchronous, active-low reset
rx_in  in  1  synchronized serial line, idle high
prescale  in  6  oversampling ratio; legal values 8, 16, 32
par_en  in  1  1 = frame carries a parity bit
par_typ  in  1  0 = even, 1 = odd
sampled_bit  in  1  voted bit from the sampling stage; stable by edge_count == prescale-1
edge_count  out  6  edge index within the current bit, 0..prescale-1
bit_count  out  4  bit index within the frame; start bit = 0
dat_samp_en  out  1  sampling-stage enable
p_data  out  8  received byte
data_valid  out  1  one-cycle pulse: byte good
par_err  out  1  one-cycle pulse: parity mismatch
stp_err  out  1  one-cycle pulse: stop bit low

Behaviour:
- Reset: all outputs 0; state IDLE; shift register 0; latched prescale = 16.
- The edge counter runs only outside IDLE. It counts 0..P-1, then wraps to 0, and bit_count increments on the wrap. P is the prescale value latched on start detect and held for the whole frame. Non-legal prescale values are latched as 16.
- "Bit end" = the cycle where edge_count == P-1. All sampled_bit consumption occurs only on bit end.
- dat_samp_en = 1 in every state except IDLE.
- IDLE: if rx_in == 0 -> START, with edge_count = 0 and bit_count = 0 on the next cycle. Otherwise stay.
- START: at bit end, if sampled_bit == 1 (glitch) -> IDLE, with no error pulse and counters cleared. Otherwise -> DATA.
- DATA: at each bit end, shift sampled_bit into the MSB of the shift register (right shift, LSB-first line order). After the 8th data bit (bit_count == 8 at bit end): -> PARITY if par_en, else -> STOP.
- PARITY: at bit end, expected = (^shift) ^ par_typ. If sampled_bit != expected, latch a parity-fail flag. -> STOP.
- STOP: at bit end:
  - stp_err = ~sampled_bit for one cycle.
  - par_err = the parity-fail flag for one cycle.
  - If neither error: p_data <= shift and data_valid = 1 for one cycle.
  - -> IDLE; counters and flag cleared.
- p_data holds its value until the next good frame and is never updated on an errored frame.
- par_en and par_typ are sampled at start detect and held for the frame.
- Back-to-back frames: IDLE re-detects a low rx_in on the cycle after STOP exits. One cycle of phase slip per frame is acceptable.
- Async reset mid-frame: immediate return to the reset state; no pulses are emitted.

Decomposition:
- Package uart_rx_pkg holds:
  - state enum IDLE/START/DATA/PARITY/STOP, 3-bit encoding;
  - constants DATA_BITS = 8 and DEFAULT_PRESCALE = 16;
  - the legal-prescale check function.
- Natural sub-module: uart_rx_edge_bit_counter (edge_count/bit_count with enable, wrap at P-1, synchronous clear). The FSM, deserializer and checks stay in this top.

Test Plan:
- prescale=16, par_en=0, frame 0xA5 (start, 10100101 sent LSB first, stop 1) -> p_data=0xA5 and one data_valid pulse at start-detect + 160 cycles, ±1. No error pulses.
- prescale=8, par_en=1, par_typ=0, byte 0x3C, parity bit 0 -> data_valid, p_data=0x3C. Repeat with parity bit 1 -> par_err pulse, no data_valid, p_data unchanged.
- prescale=32, byte 0x81, stop bit driven 0 -> stp_err pulse only; return to IDLE; the next good frame 0x55 is received.
- rx_in low for 4 cycles then high (prescale=16) -> back to IDLE after 16 cycles; no pulses; edge_count = 0.
- Two frames back-to-back, 0x0F then 0xF0, prescale=16, par_en=1, odd parity -> two data_valid pulses with the correct bytes.
- Assert rst low at DATA bit 4 -> all outputs 0 immediately; a following frame 0x99 is received correctly.
